// File: rtl/aes_session_ctrl.sv
// Session sequencer for the 16-bit AES demo: plaintext capture, encryption handshake,
// password gating with failure counting and timed lockout. All outputs except enc_start are Moore.
module aes_session_ctrl #(
    parameter int unsigned AES_TIMEOUT    = 64,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100_000_000
) (
    input  logic        CLKIN,
    input  logic        RESET,
    input  logic        load_btn,
    input  logic [15:0] plain_in,
    input  logic        enc_done,
    input  logic [15:0] enc_data,
    input  logic        pw_ok,
    input  logic        pw_bad,
    output logic        enc_start,
    output logic [15:0] enc_in,
    output logic [15:0] cipher_reg,
    output logic [1:0]  disp_sel,
    output logic        pw_arm,
    output logic        locked,
    output logic        busy,
    output logic [3:0]  led_status
);

    localparam int unsigned TW = (AES_TIMEOUT > 1) ? $clog2(AES_TIMEOUT) : 1;
    localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(AES_TIMEOUT - 1);
    localparam logic [LW-1:0] LK_LAST  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    TRY_LAST = 2'(MAX_TRIES - 1);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StEncrypt   = 3'd1;
    localparam logic [2:0] StWaitPw    = 3'd2;
    localparam logic [2:0] StShowPlain = 3'd3;
    localparam logic [2:0] StLockout   = 3'd4;
    localparam logic [2:0] StError     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          load_q;
    logic          ld_edge;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [1:0]    tries_q, tries_d;
    logic [15:0]   enc_in_d, cipher_d;
    logic          start_d;
    logic [1:0]    disp_d;
    logic [3:0]    led_d;

    assign ld_edge = load_btn & ~load_q;

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        lcnt_d   = lcnt_q;
        tries_d  = tries_q;
        enc_in_d = enc_in;
        cipher_d = cipher_reg;
        start_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (ld_edge) begin
                    enc_in_d = plain_in;
                    tcnt_d   = '0;
                    start_d  = 1'b1;
                    state_d  = StEncrypt;
                end
            end
            StEncrypt: begin
                // enc_done takes priority over the timeout in the terminal cycle
                if (enc_done) begin
                    cipher_d = enc_data;
                    tries_d  = '0;
                    state_d  = StWaitPw;
                end else if (tcnt_q == TO_LAST) begin
                    state_d = StError;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StWaitPw: begin
                if (pw_bad) begin
                    tries_d = tries_q + 2'd1;
                    if (tries_q == TRY_LAST) begin
                        lcnt_d  = '0;
                        state_d = StLockout;
                    end
                end else if (pw_ok) begin
                    state_d = StShowPlain;
                end
            end
            StShowPlain: begin
                if (ld_edge) begin
                    tries_d = '0;
                    state_d = StIdle;
                end
            end
            StLockout: begin
                if (lcnt_q == LK_LAST) begin
                    tries_d = '0;
                    state_d = StWaitPw;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            StError: begin
                if (ld_edge) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with state_q
    always_comb begin
        disp_d = 2'b00;
        case (state_d)
            StWaitPw:             disp_d = 2'b01;
            StShowPlain:          disp_d = 2'b10;
            StLockout, StError:   disp_d = 2'b11;
            default:              disp_d = 2'b00;
        endcase
        led_d = {state_d == StError, tries_d > 2'd2, tries_d > 2'd1, tries_d > 2'd0};
    end

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            load_q     <= 1'b1;
            tcnt_q     <= '0;
            lcnt_q     <= '0;
            tries_q    <= '0;
            enc_in     <= '0;
            cipher_reg <= '0;
            enc_start  <= 1'b0;
            disp_sel   <= 2'b00;
            pw_arm     <= 1'b0;
            locked     <= 1'b0;
            busy       <= 1'b0;
            led_status <= '0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_btn;
            tcnt_q     <= tcnt_d;
            lcnt_q     <= lcnt_d;
            tries_q    <= tries_d;
            enc_in     <= enc_in_d;
            cipher_reg <= cipher_d;
            enc_start  <= start_d;
            disp_sel   <= disp_d;
            pw_arm     <= (state_d == StWaitPw);
            locked     <= (state_d == StLockout);
            busy       <= (state_d == StEncrypt);
            led_status <= led_d;
        end
    end

endmodule

// File: tb/tb_aes_session_ctrl.sv
// Directed-plus-random bench for aes_session_ctrl against a transaction-level session model.
module tb_aes_session_ctrl;

    localparam int AES_TO = 64;
    localparam int MAXT   = 3;
    localparam int LOCK   = 20;

    localparam int M_IDLE = 0;
    localparam int M_ENC  = 1;
    localparam int M_WAIT = 2;
    localparam int M_SHOW = 3;
    localparam int M_LOCK = 4;
    localparam int M_ERR  = 5;

    logic        CLKIN = 1'b0;
    logic        RESET;
    logic        load_btn;
    logic [15:0] plain_in;
    logic        enc_done;
    logic [15:0] enc_data;
    logic        pw_ok;
    logic        pw_bad;
    logic        enc_start;
    logic [15:0] enc_in;
    logic [15:0] cipher_reg;
    logic [1:0]  disp_sel;
    logic        pw_arm;
    logic        locked;
    logic        busy;
    logic [3:0]  led_status;

    int          nchecks = 0;
    int          nerr    = 0;
    int          m_mode;
    int          m_tries;
    logic [15:0] m_cipher;
    logic [15:0] m_plain;

    aes_session_ctrl #(
        .AES_TIMEOUT    (AES_TO),
        .MAX_TRIES      (MAXT),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .CLKIN      (CLKIN),
        .RESET      (RESET),
        .load_btn   (load_btn),
        .plain_in   (plain_in),
        .enc_done   (enc_done),
        .enc_data   (enc_data),
        .pw_ok      (pw_ok),
        .pw_bad     (pw_bad),
        .enc_start  (enc_start),
        .enc_in     (enc_in),
        .cipher_reg (cipher_reg),
        .disp_sel   (disp_sel),
        .pw_arm     (pw_arm),
        .locked     (locked),
        .busy       (busy),
        .led_status (led_status)
    );

    always #5 CLKIN = ~CLKIN;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Expected {disp_sel, pw_arm, locked, busy, led_status} for a session mode
    function automatic logic [8:0] exp_vec(input int mode, input int tries);
        logic [1:0] d;
        logic       pa, lk, bz, er;
        logic [2:0] th;
        th = 3'((1 << tries) - 1);
        d = 2'b00; pa = 1'b0; lk = 1'b0; bz = 1'b0; er = 1'b0;
        case (mode)
            M_ENC:  bz = 1'b1;
            M_WAIT: begin d = 2'b01; pa = 1'b1; end
            M_SHOW: d = 2'b10;
            M_LOCK: begin d = 2'b11; lk = 1'b1; end
            M_ERR:  begin d = 2'b11; er = 1'b1; end
            default: d = 2'b00;
        endcase
        return {d, pa, lk, bz, er, th};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk(tag, 32'({disp_sel, pw_arm, locked, busy, led_status}), 32'(exp_vec(m_mode, m_tries)));
        chk({tag, "_cipher"}, 32'(cipher_reg), 32'(m_cipher));
        chk({tag, "_encin"}, 32'(enc_in), 32'(m_plain));
    endtask

    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    // lat: ENCRYPT cycle (1-based) in which enc_done pulses; outside 1..AES_TO means never
    task automatic encrypt(input logic [15:0] plain, input logic [15:0] cipher, input int lat);
        plain_in = plain;
        load_btn = 1'b1;
        tick();
        load_btn = 1'b0;
        m_mode   = M_ENC;
        m_plain  = plain;
        chk("enc_start_pulse", 32'(enc_start), 32'd1);
        chk_state("enc_entry");
        for (int k = 1; k <= AES_TO; k++) begin
            if (k == 2) chk("enc_start_once", 32'(enc_start), 32'd0);
            if (k == AES_TO) chk_state("enc_last_cycle");
            enc_done = (k == lat);
            enc_data = (k == lat) ? cipher : 16'($urandom);
            tick();
            enc_done = 1'b0;
            if (k == lat) break;
        end
        if (lat >= 1 && lat <= AES_TO) begin
            m_mode   = M_WAIT;
            m_cipher = cipher;
            m_tries  = 0;
        end else begin
            m_mode = M_ERR;
        end
        chk_state("enc_result");
        if (m_mode == M_ERR) begin
            enc_done = 1'b1;
            enc_data = ~cipher;
            tick();
            enc_done = 1'b0;
            chk_state("err_late_done");
        end
    endtask

    // kind: 0 = pw_ok, 1 = pw_bad, 2 = both together
    task automatic attempt(input int kind);
        pw_ok  = (kind != 1);
        pw_bad = (kind != 0);
        tick();
        pw_ok  = 1'b0;
        pw_bad = 1'b0;
        if (kind == 0) begin
            m_mode = M_SHOW;
        end else begin
            m_tries++;
            if (m_tries == MAXT) m_mode = M_LOCK;
        end
        chk_state("pw_attempt");
    endtask

    task automatic lockout_wait();
        for (int c = 1; c <= LOCK; c++) begin
            chk_state("lock_hold");
            pw_ok  = 1'($urandom);
            pw_bad = 1'($urandom);
            tick();
        end
        pw_ok   = 1'b0;
        pw_bad  = 1'b0;
        m_mode  = M_WAIT;
        m_tries = 0;
        chk_state("lock_exit");
    endtask

    task automatic press(input logic [15:0] new_plain);
        plain_in = new_plain;
        load_btn = 1'b1;
        tick();
        load_btn = 1'b0;
        if (m_mode == M_SHOW) begin
            m_mode  = M_IDLE;
            m_tries = 0;
        end else if (m_mode == M_ERR) begin
            m_mode = M_IDLE;
        end
        chk_state("press");
        tick();
        chk_state("press_settle");
    endtask

    initial begin
        RESET    = 1'b1;
        load_btn = 1'b0;
        plain_in = '0;
        enc_done = 1'b0;
        enc_data = '0;
        pw_ok    = 1'b0;
        pw_bad   = 1'b0;
        m_mode   = M_IDLE;
        m_tries  = 0;
        m_cipher = '0;
        m_plain  = '0;
        repeat (2) @(posedge CLKIN);
        #1;
        chk_state("reset");
        chk("reset_start", 32'(enc_start), 32'd0);
        RESET = 1'b0;
        tick();
        tick();

        // Basic encryption then two failures and a success
        encrypt(16'hBEEF, 16'h3A5C, 10);
        attempt(1);
        attempt(1);
        attempt(0);
        press(16'h0101);

        // Lockout path, retained ciphertext
        encrypt(16'h1234, 16'h5678, 5);
        attempt(1);
        attempt(1);
        attempt(1);
        lockout_wait();
        attempt(0);
        press(16'h0202);

        // Timeout and enc_done in the terminal cycle
        encrypt(16'hAAAA, 16'h5555, 0);
        press(16'h0303);
        encrypt(16'hC0DE, 16'hF00D, AES_TO);

        // Simultaneous pulses count as a failure; button ignored while armed
        attempt(2);
        press(16'h9999);
        attempt(0);
        press(16'h0404);

        // Button held through reset gives no edge
        load_btn = 1'b1;
        #2 RESET = 1'b1;
        #1;
        m_mode = M_IDLE; m_tries = 0; m_cipher = '0; m_plain = '0;
        chk_state("async_reset");
        tick();
        RESET = 1'b0;
        tick();
        tick();
        chk_state("held_btn_idle");
        load_btn = 1'b0;
        tick();

        // Reset during the start pulse drops it; late enc_done ignored
        plain_in = 16'h7777;
        load_btn = 1'b1;
        tick();
        chk("start_before_rst", 32'(enc_start), 32'd1);
        RESET = 1'b1;
        #1;
        chk("start_dropped", 32'(enc_start), 32'd0);
        chk_state("rst_in_encrypt");
        load_btn = 1'b0;
        tick();
        RESET = 1'b0;
        enc_done = 1'b1;
        enc_data = 16'hDEAD;
        tick();
        enc_done = 1'b0;
        chk_state("late_done_ignored");
        tick();

        // Randomized sessions
        for (int s = 0; s < 10; s++) begin
            int r;
            int lat;
            r = int'($urandom_range(0, 9));
            if (r < 7)       lat = int'($urandom_range(1, AES_TO));
            else if (r == 7) lat = AES_TO;
            else if (r == 8) lat = AES_TO + 1;
            else             lat = 0;
            encrypt(16'($urandom), 16'($urandom), lat);
            if (m_mode == M_ERR) begin
                press(16'($urandom));
                continue;
            end
            for (int a = 0; a < 12 && m_mode != M_SHOW; a++) begin
                if (m_mode == M_LOCK) lockout_wait();
                else attempt(int'($urandom_range(0, 2)));
            end
            if (m_mode == M_LOCK) lockout_wait();
            if (m_mode == M_WAIT) attempt(0);
            press(16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
